// File: rtl/mips_ctl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: state encodings,
// opcodes, ALU/mux select codes and small dispatch helpers.
package mips_ctl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REXE    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_IEXE    = 4'd11,
    S_IWB     = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ITYPE  = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ADD    = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:     return S_MEMADDR;
      OP_RTYPE:         return S_REXE;
      OP_BEQ, OP_BNE:   return S_BRANCH;
      OP_J:             return S_JUMP;
      OP_ADDI, OP_ANDI: return S_IEXE;
      default:          return S_TRAP;
    endcase
  endfunction

  // Where a memory-access state goes once the memory signals completion.
  function automatic state_t mem_done_next(input state_t s);
    case (s)
      S_FETCH: return S_DECODE;
      S_MEMRD: return S_MEMWB;
      default: return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctl_decode.sv
// Combinational decode of the FSM state into the datapath control vector.
// Only the fetch strobes that load IR/PC look at mem_ready.
module mc_ctl_decode
  import mips_ctl_pkg::*;
(
  input  logic       state_valid,
  input  state_t     state,
  input  logic       op_lsb,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       alu_funct_sel,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_ITYPE;
    alu_funct_sel = 1'b0;
    pc_source     = PCSRC_ALU;
    if (state_valid) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOP_ADD;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          alu_op    = ALUOP_ADD;
        end
        S_MEMADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_REXE: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_RTYPE;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_BRANCH;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          branch_ne     = op_lsb;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        S_IEXE: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_IMM;
          alu_funct_sel = 1'b1;
        end
        S_IWB: begin
          reg_write     = 1'b1;
          alu_funct_sel = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle MIPS core: state sequencing, memory wait
// timeout and sticky trap flags. Define MC_PERF_CNT_EN to add the retired-instruction counter.
module mc_control_fsm
  import mips_ctl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        branch_ne,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        alu_funct_sel,
  output logic [1:0]  pc_source,
  output logic        illegal,
  output logic        mem_err,
  output logic [31:0] instr_count
);

  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);

  state_t          state;
  logic [TO_W-1:0] wait_cnt;
  logic            illegal_q;
  logic            mem_err_q;

  // The wait counter holds the number of consecutive mem_ready-low cycles in the
  // current access; a completion in the cycle it sits at the limit still wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (mem_ready) begin
            state <= mem_done_next(state);
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state     <= S_TRAP;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end
        S_DECODE: begin
          state <= dispatch(opcode);
          if (dispatch(opcode) == S_TRAP) illegal_q <= 1'b1;
        end
        S_MEMADDR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_REXE:    state <= S_RWB;
        S_IEXE:    state <= S_IWB;
        S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state <= S_FETCH;
        S_TRAP:    state <= S_TRAP;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign mem_err = mem_err_q;

  mc_ctl_decode u_decode (
    .state_valid   (1'b1),
    .state         (state),
    .op_lsb        (opcode[0]),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .alu_funct_sel (alu_funct_sel),
    .pc_source     (pc_source)
  );

`ifdef MC_PERF_CNT_EN
  logic [31:0] count_q;
  logic        retire;

  assign retire = (state inside {S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP}) ||
                  ((state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= 32'd0;
    else if (retire) count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction phase model built
// from the instruction classes, with random opcodes and memory wait states.
module tb_mc_control_fsm;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_funct_sel;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        illegal, mem_err;
  logic [31:0] instr_count;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       alu_funct_sel;
    logic [1:0] pc_source;
    logic       illegal, mem_err;
  } ctl_t;

  typedef enum {PH_FETCH, PH_DECODE, PH_MEMADDR, PH_MEMRD, PH_MEMWB, PH_MEMWR, PH_REXE,
                PH_RWB, PH_BRANCH, PH_JUMP, PH_IEXE, PH_IWB, PH_TRAP, PH_TIMEOUT} ph_e;

  typedef struct {
    ph_e  ph;
    logic rdy;
  } step_t;

  ctl_t obs;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   retired  = 0;

  assign obs = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, alu_funct_sel, pc_source, illegal, mem_err};

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .alu_funct_sel(alu_funct_sel), .pc_source(pc_source), .illegal(illegal),
    .mem_err(mem_err), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int exp_count();
`ifdef MC_PERF_CNT_EN
    return retired;
`else
    return 0;
`endif
  endfunction

  function automatic step_t mk(input ph_e ph, input logic rdy);
    step_t s;
    s.ph  = ph;
    s.rdy = rdy;
    return s;
  endfunction

  // Control vector each phase must present, straight from the phase descriptions.
  function automatic ctl_t expect_phase(input ph_e ph, input logic rdy, input logic [5:0] op);
    ctl_t c = '0;
    case (ph)
      PH_FETCH:   begin c.mem_read = 1; c.ir_write = rdy; c.pc_write = rdy;
                        c.alu_src_b = 2'b01; c.alu_op = 2'b11; end
      PH_DECODE:  begin c.alu_src_b = 2'b11; c.alu_op = 2'b11; end
      PH_MEMADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      PH_MEMRD:   begin c.mem_read = 1; c.iord = 1; end
      PH_MEMWB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
      PH_MEMWR:   begin c.mem_write = 1; c.iord = 1; end
      PH_REXE:    begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      PH_RWB:     begin c.reg_write = 1; c.reg_dst = 1; end
      PH_BRANCH:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                        c.pc_source = 2'b01; c.branch_ne = op[0]; end
      PH_JUMP:    begin c.pc_write = 1; c.pc_source = 2'b10; end
      PH_IEXE:    begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_funct_sel = 1; end
      PH_IWB:     begin c.reg_write = 1; c.alu_funct_sel = 1; end
      PH_TRAP:    c.illegal = 1;
      PH_TIMEOUT: c.mem_err = 1;
      default:    ;
    endcase
    return c;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    retired = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one instruction from its first fetch cycle, checking every cycle.
  task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait);
    step_t seq[$];
    ctl_t  exp;
    bit    retires = 1;
    opcode = op;
    for (int i = 0; i < fetch_wait; i++) seq.push_back(mk(PH_FETCH, 1'b0));
    seq.push_back(mk(PH_FETCH, 1'b1));
    seq.push_back(mk(PH_DECODE, 1'($urandom_range(0, 1))));
    case (op)
      6'h23: begin
        seq.push_back(mk(PH_MEMADDR, 1'($urandom_range(0, 1))));
        for (int i = 0; i < mem_wait; i++) seq.push_back(mk(PH_MEMRD, 1'b0));
        seq.push_back(mk(PH_MEMRD, 1'b1));
        seq.push_back(mk(PH_MEMWB, 1'($urandom_range(0, 1))));
      end
      6'h2B: begin
        seq.push_back(mk(PH_MEMADDR, 1'($urandom_range(0, 1))));
        for (int i = 0; i < mem_wait; i++) seq.push_back(mk(PH_MEMWR, 1'b0));
        seq.push_back(mk(PH_MEMWR, 1'b1));
      end
      6'h00: begin
        seq.push_back(mk(PH_REXE, 1'($urandom_range(0, 1))));
        seq.push_back(mk(PH_RWB, 1'($urandom_range(0, 1))));
      end
      6'h04, 6'h05: seq.push_back(mk(PH_BRANCH, 1'($urandom_range(0, 1))));
      6'h02:        seq.push_back(mk(PH_JUMP, 1'($urandom_range(0, 1))));
      6'h08, 6'h0C: begin
        seq.push_back(mk(PH_IEXE, 1'($urandom_range(0, 1))));
        seq.push_back(mk(PH_IWB, 1'($urandom_range(0, 1))));
      end
      default: begin
        retires = 0;
        repeat (4) seq.push_back(mk(PH_TRAP, 1'($urandom_range(0, 1))));
      end
    endcase
    foreach (seq[k]) begin
      @(negedge clk);
      mem_ready = seq[k].rdy;
      #1;
      exp = expect_phase(seq[k].ph, seq[k].rdy, op);
      n_checks++;
      if (obs !== exp)
        $display("[TB] FAIL %s op=%h step %0d: got %h, expected %h",
                 seq[k].ph.name(), op, k, obs, exp);
      else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (instr_count !== 32'(exp_count()))
          $display("[TB] FAIL instr_count op=%h: got %0d, expected %0d", op, instr_count, exp_count());
        else n_pass++;
      end
    end
    if (retires) retired++;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (obs !== '0 || instr_count !== 32'd0)
      $display("[TB] FAIL reset_outputs: got %h/%0d, expected 0/0", obs, instr_count);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) $display("[TB] FAIL idle_outputs: got %h, expected 0", obs);
    else n_pass++;
  endtask

  task automatic test_lw();       run_instr(6'h23, 0, 0); endtask
  task automatic test_addi();     run_instr(6'h08, 0, 0); run_instr(6'h0C, 1, 0); endtask
  task automatic test_rtype();    run_instr(6'h00, 0, 0); endtask
  task automatic test_branch();   run_instr(6'h05, 0, 0); run_instr(6'h04, 0, 0); endtask
  task automatic test_jump();     run_instr(6'h02, 2, 0); endtask
  task automatic test_sw_wait();  run_instr(6'h2B, 0, 3); endtask

  task automatic test_timeout();
    ctl_t exp;
    apply_reset();
    opcode = 6'h08;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      exp = expect_phase(PH_FETCH, 1'b0, 6'h08);
      n_checks++;
      if (obs !== exp) $display("[TB] FAIL timeout_wait cyc %0d: got %h, expected %h", i, obs, exp);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      exp = expect_phase(PH_TIMEOUT, 1'b0, 6'h08);
      n_checks++;
      if (obs !== exp) $display("[TB] FAIL timeout_trap cyc %0d: got %h, expected %h", i, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_timeout_boundary();
    apply_reset();
    run_instr(6'h08, 15, 0);
    run_instr(6'h23, 0, 15);
    run_instr(6'h2B, 0, 15);
  endtask

  task automatic test_illegal();
    apply_reset();
    run_instr(6'h3F, 0, 0);
  endtask

  task automatic test_reset_mid_memrd();
    apply_reset();
    opcode = 6'h23;
    repeat (3) begin
      @(negedge clk);
      mem_ready = 1'b1;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_read !== 1'b1 || iord !== 1'b1)
      $display("[TB] FAIL memrd_before_reset: got rd=%b iord=%b, expected 1/1", mem_read, iord);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    retired = 0;
    n_checks++;
    if (obs !== '0 || instr_count !== 32'd0)
      $display("[TB] FAIL async_reset: got %h/%0d, expected 0/0", obs, instr_count);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    run_instr(6'h23, 0, 1);
  endtask

  task automatic test_perf();
    apply_reset();
    run_instr(6'h00, 0, 0);
    run_instr(6'h02, 0, 0);
    run_instr(6'h2B, 0, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (instr_count !== 32'(exp_count()))
      $display("[TB] FAIL perf_count: got %0d, expected %0d", instr_count, exp_count());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h23, 6'h2B};
    apply_reset();
    for (int n = 0; n < 30; n++)
      run_instr(ops[$urandom_range(0, 7)], int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'h00;
    test_reset();
    test_lw();
    test_addi();
    test_rtype();
    test_branch();
    test_jump();
    test_sw_wait();
    test_timeout();
    test_timeout_boundary();
    test_illegal();
    test_reset_mid_memrd();
    test_perf();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
